gpr_scoreboard_bypass: RTL
==========================

Name: gpr_scoreboard_bypass

Overview:
- Parametrised successor to the ID-stage GPR forwarding logic.
- Resolves every ID read port against N younger pipeline stages, with the youngest stage taking priority.
- Adds a per-register countdown scoreboard so multi-cycle units (mul/div, cache-miss loads) stall dependent instructions until their result reaches a forwarding stage.
- Sits between the register file read ports and the ID/EXE pipeline register; drives the ID stall.

Parameters:
- XLEN, 32, data width.
- NREGS, 32, number of GPRs; register 0 is hardwired zero.
- NUM_RD, 2, number of ID read ports.
- NUM_FWD, 2, number of forwarding stages; index 0 is the youngest (EXE).
- MAX_LAT, 15, maximum issue latency in cycles; counter width CW = clog2(MAX_LAT+1).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_ID_ren  in  NUM_RD  per-port read enable.
- i_ID_raddr  in  NUM_RD*AW  read addresses, AW = clog2(NREGS).
- i_ID_rdata  in  NUM_RD*XLEN  register file read data.
- i_FWD_we  in  NUM_FWD  stage writes a GPR.
- i_FWD_ready  in  NUM_FWD  stage result is valid this cycle.
- i_FWD_waddr  in  NUM_FWD*AW  stage destination register.
- i_FWD_wdata  in  NUM_FWD*XLEN  stage result.
- i_issue_valid  in  1  ID instruction is attempting to issue.
- i_issue_we  in  1  issuing instruction writes a GPR.
- i_issue_waddr  in  AW  its destination register.
- i_issue_lat  in  CW  cycles until its result appears on a forwarding stage; 0 means not scoreboarded.
- i_flush  in  1  pipeline flush.
- o_ID_valid_rdata  out  NUM_RD*XLEN  resolved operands.
- o_stall  out  1  hold ID; issue is not accepted.
- o_busy_vec  out  NREGS  per-register scoreboard busy flags.
- o_stall_cycles  out  32  saturating performance counter.

Behaviour:
- Reset (asynchronous on i_rst_n low):
  - All cnt[r] = 0 and o_stall_cycles = 0.
  - As a result, o_busy_vec = 0 and o_stall = 0 for any idle input.
- Forwarding, per port p (combinational):
  - Scan stages 0..NUM_FWD-1 for the first stage s with we[s] && waddr[s] != 0 && waddr[s] == raddr[p].
  - If that stage has ready[s] = 1, output wdata[s].
  - If the first match has ready = 0, port p is hazarded. There is no fall-through to an older stage.
  - If there is no match, output rdata[p].
  - raddr = 0 always outputs rdata[p] and is never hazarded.
- Scoreboard hazard:
  - Port p is also hazarded if ren[p] && cnt[raddr[p]] != 0 and no ready forwarding match exists.
  - A ready forwarding match overrides busy; this covers the cycle in which the result arrives.
- Stall:
  - o_stall = i_issue_valid && (any ren[p] with hazard[p]).
  - A port with ren = 0 never stalls.
  - Issue is accepted when i_issue_valid && !o_stall.
- Counter update per register r, in priority order:
  1. i_flush: cnt <= 0 for all registers. Issue is ignored in the same cycle.
  2. Accepted issue with i_issue_we, waddr == r != 0, lat != 0: cnt[r] <= lat. WAW overwrites any in-flight count.
  3. cnt[r] != 0: cnt[r] <= cnt[r] - 1.
  4. Otherwise hold.
  - cnt[0] is constant 0.
  - i_issue_lat > MAX_LAT cannot be represented and is a caller error; the assertion flags it.
- Busy timing:
  - o_busy_vec[r] = (cnt[r] != 0).
  - Issue with lat = L makes the register busy from the next cycle for exactly L cycles.
- Performance counter: o_stall_cycles increments each cycle o_stall = 1, saturates at 0xFFFFFFFF, and is cleared only by reset.
- Combinational path: inputs to o_ID_valid_rdata and o_stall; no registered outputs other than the counters.

Decomposition:
- Shared package gpr_bypass_pkg:
  - AW and CW helper functions.
  - REG_ZERO constant.
  - A stage-descriptor struct {we, ready, waddr, wdata}.
- One natural sub-module, gpr_fwd_mux: a single-port priority forwarding resolver that outputs data and a hazard flag.
  - Instantiate it NUM_RD times via generate.
  - The scoreboard counters stay in the top level.

Test Plan:
- Stage 0: we=1, ready=1, waddr=5, wdata=0xAAAA; stage 1: we=1, waddr=5, wdata=0xBBBB; raddr0=5 -> rdata0 = 0xAAAA (youngest wins), stall = 0.
- Stage 0: waddr=7, ready=0; stage 1: waddr=7, ready=1; raddr1=7, ren=1, issue_valid=1 -> stall = 1, no fall-through. Same stimulus with ren1=0 -> stall = 0.
- Issue we=1, waddr=9, lat=3:
  - busy_vec[9] = 1 for exactly 3 cycles.
  - A dependent read of r9 stalls during those cycles.
  - In cycle 3, a ready stage-0 match with waddr=9 and wdata=0x1234 releases the stall with rdata = 0x1234.
- Issue r4 with lat=5, then after 2 cycles issue r4 with lat=2 -> cnt reloads to 2; busy clears 2 cycles after the second issue.
- Multiple registers busy and i_flush asserted together with an issue of r3, lat=4 -> all cnt = 0 next cycle and r3 is not set. Reset asserted mid-count -> busy_vec = 0 immediately, without waiting for a clock.
- Held stall for 10 cycles -> o_stall_cycles = 10. A read of raddr=0 while register-0 writes are present on the stages -> rdata passes through unchanged and no stall.

Source files
------------

// File: rtl/gpr_bypass_pkg.sv
// Shared types and sizing helpers for the ID-stage GPR bypass/scoreboard.
// Imported by the forwarding resolver and the scoreboard top.
package gpr_bypass_pkg;

    localparam int REG_ZERO = 0;

    function automatic int aw_of(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    function automatic int cw_of(input int max_lat);
        return (max_lat > 0) ? $clog2(max_lat + 1) : 1;
    endfunction

    typedef struct packed {
        logic        we;
        logic        ready;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } fwd_stage_t;

endpackage

// File: rtl/gpr_fwd_mux.sv
// Single read-port priority forwarding resolver; stage 0 is youngest.
// The first matching stage decides: ready gives data, not-ready is a hazard.
module gpr_fwd_mux
    import gpr_bypass_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int AW      = 5,
    parameter int NUM_FWD = 2
) (
    input  logic [AW-1:0]           raddr,
    input  logic [XLEN-1:0]         rdata,
    input  logic [NUM_FWD-1:0]      fwd_we,
    input  logic [NUM_FWD-1:0]      fwd_ready,
    input  logic [NUM_FWD*AW-1:0]   fwd_waddr,
    input  logic [NUM_FWD*XLEN-1:0] fwd_wdata,
    output logic [XLEN-1:0]         data,
    output logic                    pend,
    output logic                    hit
);

    logic found;

    always_comb begin
        data  = rdata;
        pend  = 1'b0;
        hit   = 1'b0;
        found = 1'b0;
        for (int s = 0; s < NUM_FWD; s++) begin
            if (!found && fwd_we[s]
                && fwd_waddr[s*AW +: AW] != AW'(REG_ZERO)
                && fwd_waddr[s*AW +: AW] == raddr) begin
                found = 1'b1;
                if (fwd_ready[s]) begin
                    hit  = 1'b1;
                    data = fwd_wdata[s*XLEN +: XLEN];
                end else begin
                    pend = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gpr_scoreboard_bypass.sv
// ID-stage operand bypass with a per-GPR countdown scoreboard for
// multi-cycle producers; drives the ID stall and a stall-cycle counter.
module gpr_scoreboard_bypass
    import gpr_bypass_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int NUM_RD  = 2,
    parameter int NUM_FWD = 2,
    parameter int MAX_LAT = 15,
    localparam int AW     = aw_of(NREGS),
    localparam int CW     = cw_of(MAX_LAT)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_RD-1:0]       i_ID_ren,
    input  logic [NUM_RD*AW-1:0]    i_ID_raddr,
    input  logic [NUM_RD*XLEN-1:0]  i_ID_rdata,
    input  logic [NUM_FWD-1:0]      i_FWD_we,
    input  logic [NUM_FWD-1:0]      i_FWD_ready,
    input  logic [NUM_FWD*AW-1:0]   i_FWD_waddr,
    input  logic [NUM_FWD*XLEN-1:0] i_FWD_wdata,
    input  logic                    i_issue_valid,
    input  logic                    i_issue_we,
    input  logic [AW-1:0]           i_issue_waddr,
    input  logic [CW-1:0]           i_issue_lat,
    input  logic                    i_flush,
    output logic [NUM_RD*XLEN-1:0]  o_ID_valid_rdata,
    output logic                    o_stall,
    output logic [NREGS-1:0]        o_busy_vec,
    output logic [31:0]             o_stall_cycles
);

    logic [CW-1:0]     cnt [NREGS];
    logic [NUM_RD-1:0] pend;
    logic [NUM_RD-1:0] hit;
    logic [NUM_RD-1:0] hazard;
    logic              load;

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            o_busy_vec[r] = (cnt[r] != '0);
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        gpr_fwd_mux #(
            .XLEN    (XLEN),
            .AW      (AW),
            .NUM_FWD (NUM_FWD)
        ) u_mux (
            .raddr     (i_ID_raddr[p*AW +: AW]),
            .rdata     (i_ID_rdata[p*XLEN +: XLEN]),
            .fwd_we    (i_FWD_we),
            .fwd_ready (i_FWD_ready),
            .fwd_waddr (i_FWD_waddr),
            .fwd_wdata (i_FWD_wdata),
            .data      (o_ID_valid_rdata[p*XLEN +: XLEN]),
            .pend      (pend[p]),
            .hit       (hit[p])
        );

        // A ready forward covers the cycle the busy result lands.
        assign hazard[p] = pend[p]
            | (o_busy_vec[i_ID_raddr[p*AW +: AW]] & ~hit[p]);
    end

    assign o_stall = i_issue_valid & |(i_ID_ren & hazard);

    assign load = i_issue_valid & ~o_stall & i_issue_we
                & (i_issue_lat != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (r == REG_ZERO || i_flush) begin
                    cnt[r] <= '0;
                end else if (load && i_issue_waddr == AW'(r)) begin
                    cnt[r] <= i_issue_lat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cycles <= '0;
        end else if (o_stall && o_stall_cycles != '1) begin
            o_stall_cycles <= o_stall_cycles + 32'd1;
        end
    end

    a_lat_range: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        (i_issue_valid && i_issue_we)
            |-> (32'(i_issue_lat) <= 32'(MAX_LAT))
    );

endmodule
